// File: rtl/multicycle_controller.sv
// Multicycle FSM controller: fetch/decode/execute/memory/write-back sequencing with
// memory wait timeouts, illegal-opcode trap and a retired-instruction counter.
module multicycle_controller #(
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned EN_UPPER  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       Opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             jmp_sel,
  output logic             jmp,
  output logic             jmpr,
  output logic             lui,
  output logic             auipc,
  output logic [1:0]       ALUOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsR, ClsI, ClsLw, ClsSw, ClsBr, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIll
  } cls_e;

  state_e               state_q, state_d;
  cls_e                 cls_q, cls_d, opc_cls;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]     instret_q, instret_d;
  logic                 started_q;
  logic                 timeout;
  logic                 retire;
  logic                 in_body;

  assign timeout = (wait_q == {TIMEOUT_W{1'b1}});

  always_comb begin
    opc_cls = ClsIll;
    case (Opcode)
      7'b0110011: opc_cls = ClsR;
      7'b0010011: opc_cls = ClsI;
      7'b0000011: opc_cls = ClsLw;
      7'b0100011: opc_cls = ClsSw;
      7'b1100011: opc_cls = ClsBr;
      7'b1101111: opc_cls = ClsJal;
      7'b1100111: opc_cls = ClsJalr;
      7'b0110111: opc_cls = (EN_UPPER != 0) ? ClsLui : ClsIll;
      7'b0010111: opc_cls = (EN_UPPER != 0) ? ClsAuipc : ClsIll;
      default:    opc_cls = ClsIll;
    endcase
  end

  // Retire point: EXEC for branches, MEM completion for stores, WB for everything else.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StExec:  retire = (cls_q == ClsBr);
      StMem:   retire = (cls_q == ClsSw) && dmem_ready;
      StWb:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = wait_q;
    instret_d = retire ? instret_q + 1'b1 : instret_q;
    case (state_q)
      StFetch: begin
        if (started_q) begin
          if (imem_ready) begin
            state_d = StDecode;
          end else if (timeout) begin
            state_d = StTrap;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      StDecode: begin
        cls_d   = opc_cls;
        state_d = (opc_cls == ClsIll) ? StTrap : StExec;
      end
      StExec: begin
        if (cls_q == ClsBr) begin
          state_d = StFetch;
          wait_d  = '0;
        end else if (cls_q == ClsLw || cls_q == ClsSw) begin
          state_d = StMem;
          wait_d  = '0;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (dmem_ready) begin
          if (cls_q == ClsSw) begin
            state_d = StFetch;
            wait_d  = '0;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StTrap;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWb: begin
        state_d = StFetch;
        wait_d  = '0;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StTrap;
    endcase
  end

  // started_q keeps every strobe low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      cls_q     <= ClsNone;
      wait_q    <= '0;
      instret_q <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      started_q <= 1'b1;
    end
  end

  assign in_body = (state_q == StExec) || (state_q == StMem) || (state_q == StWb);

  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    dmem_req = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    case (state_q)
      StFetch: begin
        imem_req = started_q;
        IRWrite  = started_q && imem_ready;
      end
      StMem: begin
        dmem_req = 1'b1;
        MemRead  = (cls_q == ClsLw);
        MemWrite = (cls_q == ClsSw);
      end
      StWb:    RegWrite = 1'b1;
      default: ;
    endcase
  end

  // Decoded controls are held from the latched class only while an instruction is in flight.
  always_comb begin
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    Branch   = 1'b0;
    jmp_sel  = 1'b0;
    jmp      = 1'b0;
    jmpr     = 1'b0;
    lui      = 1'b0;
    auipc    = 1'b0;
    ALUOp    = 2'b00;
    if (in_body) begin
      ALUSrc   = (cls_q == ClsLw) || (cls_q == ClsSw) || (cls_q == ClsI) ||
                 (cls_q == ClsJal) || (cls_q == ClsJalr) || (cls_q == ClsLui) ||
                 (cls_q == ClsAuipc);
      MemtoReg = (cls_q == ClsLw);
      Branch   = (cls_q == ClsBr);
      jmp_sel  = (cls_q == ClsJal) || (cls_q == ClsJalr);
      jmp      = (cls_q == ClsJal);
      jmpr     = (cls_q == ClsJalr);
      lui      = (cls_q == ClsLui);
      auipc    = (cls_q == ClsAuipc);
      if (cls_q == ClsR || cls_q == ClsI) begin
        ALUOp = 2'b10;
      end else if (cls_q == ClsBr) begin
        ALUOp = 2'b01;
      end
    end
  end

  // branch_taken only steers PC source in the datapath; the PC is written at every retire.
  assign PCWrite    = retire && (branch_taken || !branch_taken);
  assign instr_done = retire;
  assign illegal    = (state_q == StTrap);
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (upper decode on/off) checked every cycle
// against an instruction-level model, plus directed literal expectations.
module tb_multicycle_controller;

  localparam int TW  = 2;
  localparam int CW  = 4;
  localparam int TMO = (1 << TW) - 1;

  localparam int CR = 1, CI = 2, CLW = 3, CSW = 4, CBR = 5, CJAL = 6, CJALR = 7;
  localparam int CLUI = 8, CAUIPC = 9, CILL = 10;

  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       branch_taken = 1'b0;

  logic [1:0] imem_req, dmem_req, irw, pcw, alusrc, memtoreg, regw, mr, mw, br;
  logic [1:0] jsel, jmp, jmpr, lui, auipc, done, ill;
  logic [1:0]    alu_op [2];
  logic [2:0]    st     [2];
  logic [CW-1:0] ir     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    multicycle_controller #(
      .TIMEOUT_W (TW),
      .CNT_W     (CW),
      .EN_UPPER  (g == 0 ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Opcode       (Opcode),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .branch_taken (branch_taken),
      .imem_req     (imem_req[g]),
      .dmem_req     (dmem_req[g]),
      .IRWrite      (irw[g]),
      .PCWrite      (pcw[g]),
      .ALUSrc       (alusrc[g]),
      .MemtoReg     (memtoreg[g]),
      .RegWrite     (regw[g]),
      .MemRead      (mr[g]),
      .MemWrite     (mw[g]),
      .Branch       (br[g]),
      .jmp_sel      (jsel[g]),
      .jmp          (jmp[g]),
      .jmpr         (jmpr[g]),
      .lui          (lui[g]),
      .auipc        (auipc[g]),
      .ALUOp        (alu_op[g]),
      .state        (st[g]),
      .instr_done   (done[g]),
      .illegal      (ill[g]),
      .instret      (ir[g])
    );
  end

  // Model: phase of the current instruction, its class, wait count and retire count.
  int m_ph   [2] = '{0, 0};
  bit m_run  [2] = '{0, 0};
  int m_cls  [2] = '{0, 0};
  int m_wait [2] = '{0, 0};
  int m_ir   [2] = '{0, 0};

  function automatic int classify(input logic [6:0] op, input bit up);
    case (op)
      7'b0110011: return CR;
      7'b0010011: return CI;
      7'b0000011: return CLW;
      7'b0100011: return CSW;
      7'b1100011: return CBR;
      7'b1101111: return CJAL;
      7'b1100111: return CJALR;
      7'b0110111: return up ? CLUI : CILL;
      7'b0010111: return up ? CAUIPC : CILL;
      default:    return CILL;
    endcase
  endfunction

  function automatic bit retires(input int k);
    return (m_ph[k] == PE && m_cls[k] == CBR) ||
           (m_ph[k] == PM && m_cls[k] == CSW && dmem_ready) || (m_ph[k] == PW);
  endfunction

  function automatic logic [25:0] expected(input int k);
    int   ph = m_ph[k];
    int   c = m_cls[k];
    bit   body = (ph == PE || ph == PM || ph == PW);
    bit   ret = retires(k);
    bit   ireq = m_run[k] && ph == PF;
    logic [1:0] aop;
    logic [2:0] s3 = 3'(ph);
    aop = !body ? 2'd0 : (c == CR || c == CI) ? 2'd2 : (c == CBR) ? 2'd1 : 2'd0;
    return {ireq, 1'(ph == PM), 1'(ireq && imem_ready), 1'(ret),
            1'(body && (c == CLW || c == CSW || c == CI || c == CJAL || c == CJALR ||
                        c == CLUI || c == CAUIPC)),
            1'(body && c == CLW), 1'(ph == PW), 1'(ph == PM && c == CLW),
            1'(ph == PM && c == CSW), 1'(body && c == CBR),
            1'(body && (c == CJAL || c == CJALR)), 1'(body && c == CJAL),
            1'(body && c == CJALR), 1'(body && c == CLUI), 1'(body && c == CAUIPC),
            aop, s3, 1'(ret), 1'(ph == PT), 4'(m_ir[k])};
  endfunction

  function automatic logic [25:0] actual(input int k);
    return {imem_req[k], dmem_req[k], irw[k], pcw[k], alusrc[k], memtoreg[k], regw[k],
            mr[k], mw[k], br[k], jsel[k], jmp[k], jmpr[k], lui[k], auipc[k], alu_op[k],
            st[k], done[k], ill[k], ir[k]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_ph[k] = PF; m_run[k] = 0; m_cls[k] = 0; m_wait[k] = 0; m_ir[k] = 0;
      end else if (!m_run[k]) begin
        m_run[k] = 1;
      end else begin
        if (retires(k)) m_ir[k] = (m_ir[k] + 1) % (1 << CW);
        case (m_ph[k])
          PF: if (imem_ready) m_ph[k] = PD;
              else if (m_wait[k] == TMO) m_ph[k] = PT;
              else m_wait[k]++;
          PD: begin
            m_cls[k] = classify(Opcode, k == 0);
            m_ph[k]  = (m_cls[k] == CILL) ? PT : PE;
          end
          PE: begin
            m_ph[k] = (m_cls[k] == CBR) ? PF : (m_cls[k] == CLW || m_cls[k] == CSW) ? PM : PW;
            m_wait[k] = 0;
          end
          PM: if (dmem_ready) begin
                m_ph[k] = (m_cls[k] == CSW) ? PF : PW;
                m_wait[k] = 0;
              end else if (m_wait[k] == TMO) m_ph[k] = PT;
              else m_wait[k]++;
          PW: begin m_ph[k] = PF; m_wait[k] = 0; end
          default: m_ph[k] = PT;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [25:0] got, want;
      got  = actual(k);
      want = expected(k);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle_model dut%0d t=%0t got=%b want=%b", k, $time, got, want);
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run(1);
  endtask

  initial begin
    logic [6:0] ops [3];
    ops[0] = 7'b0010011; ops[1] = 7'b1101111; ops[2] = 7'b1100111;

    @(posedge clk); #1;
    chk("rst_state", st[0], 0);
    chk("rst_imem_req", imem_req[0], 0);
    chk("rst_instret", ir[0], 0);
    #2 rst_n = 1'b1;
    run(1);
    chk("start_imem_req", imem_req[0], 1);

    Opcode = 7'b0110011; imem_ready = 1; dmem_ready = 1;
    run(1); chk("r_decode", st[0], 1);
    run(1); chk("r_exec", st[0], 2); chk("r_exec_regwrite", regw[0], 0);
    run(1); chk("r_wb", st[0], 4); chk("r_wb_regwrite", regw[0], 1);
    chk("r_aluop", alu_op[0], 2); chk("r_done", done[0], 1);
    run(1); chk("r_instret", ir[0], 1); chk("r_fetch", st[0], 0);

    Opcode = 7'b0000011; dmem_ready = 0;
    run(3); chk("lw_mem1", st[0], 3); chk("lw_memread", mr[0], 1);
    run(3); chk("lw_mem4", st[0], 3);
    dmem_ready = 1;
    run(1); chk("lw_wb", st[0], 4); chk("lw_memtoreg", memtoreg[0], 1);
    chk("lw_regwrite", regw[0], 1);
    run(1); chk("lw_instret", ir[0], 2);

    for (int b = 0; b < 2; b++) begin
      Opcode = 7'b1100011; branch_taken = 1'(b);
      run(2);
      chk("br_state", st[0], 2); chk("br_pcwrite", pcw[0], 1); chk("br_branch", br[0], 1);
      chk("br_aluop", alu_op[0], 1); chk("br_regwrite", regw[0], 0);
      run(1); chk("br_fetch", st[0], 0);
    end
    chk("br_instret", ir[0], 4);

    Opcode = 7'b0100011; dmem_ready = 0;
    run(3); chk("sw_memwrite", mw[0], 1);
    dmem_ready = 1;
    #1 chk("sw_retire", done[0], 1);
    run(1); chk("sw_instret", ir[0], 5);

    foreach (ops[i]) begin
      Opcode = ops[i];
      run(4);
    end
    chk("misc_instret", ir[0], 8);

    Opcode = 7'b0110011;
    run(28); chk("wrap_15", ir[0], 15);
    run(4);  chk("wrap_0", ir[0], 0);
    run(4);  chk("wrap_1", ir[0], 1);

    imem_ready = 0;
    run(3); chk("late_fetch4", st[0], 0);
    imem_ready = 1;
    run(1); chk("late_decode", st[0], 1);
    run(3); chk("late_instret", ir[0], 2);

    Opcode = 7'b0100011; dmem_ready = 0;
    run(3); chk("pulse_memwrite_hi", mw[0], 1);
    #1 rst_n = 1'b0;
    #1 chk("pulse_memwrite_lo", mw[0], 0); chk("pulse_dmem_req_lo", dmem_req[0], 0);
    chk("pulse_instret", ir[0], 0);
    #1 rst_n = 1'b1;
    run(1); chk("pulse_restart", imem_req[0], 1);

    Opcode = 7'b0110111; dmem_ready = 1;
    run(2); chk("lui_exec", st[0], 2); chk("lui_flag", lui[0], 1);
    chk("lui_off_trap", st[1], 7); chk("lui_off_illegal", ill[1], 1);
    run(2); chk("lui_instret", ir[0], 1); chk("lui_off_instret", ir[1], 0);
    Opcode = 7'b0010111;
    run(4); chk("auipc_instret", ir[0], 2); chk("auipc_off_held", ill[1], 1);

    do_reset();
    Opcode = 7'b1111111;
    run(2); chk("ill_trap", st[0], 7); chk("ill_flag", ill[0], 1);
    run(3); chk("ill_held", ill[0], 1); chk("ill_instret", ir[0], 0);

    do_reset();
    imem_ready = 0;
    run(3); chk("tmo_fetch4", st[0], 0);
    run(1); chk("tmo_trap", st[0], 7);
    imem_ready = 1;
    run(2); chk("tmo_held", st[0], 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters SHALL be: TIMEOUT_W, default 4, width of the memory wait counter; CNT_W, default 16, width of the retired-instruction counter; EN_UPPER, default 1, 1 enables LUI/AUIPC decode.
REQ-002 Clock and reset SHALL be a single clock and an asynchronous, active-low reset, as listed below.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 Opcode  in  7  instruction[6:0]; sampled only in DECODE.
REQ-006 imem_ready  in  1  instruction memory data valid.
REQ-007 dmem_ready  in  1  data memory access complete.
REQ-008 branch_taken  in  1  branch condition result from the ALU compare logic.
REQ-009 imem_req, dmem_req  out  1 each  memory request strobes.
REQ-010 IRWrite, PCWrite  out  1 each  instruction-register and PC write enables.
REQ-011 ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, jmp_sel, jmp, jmpr, lui, auipc  out  1 each  datapath controls.
REQ-012 ALUOp  out  2  00 load/store/jump/upper, 01 branch, 10 R/I arithmetic.
REQ-013 state  out  3  FSM state code: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
REQ-014 instr_done  out  1  one-cycle pulse when an instruction retires.
REQ-015 illegal  out  1  high while in TRAP.
REQ-016 instret  out  CNT_W  retired-instruction count.

Function
REQ-017 FETCH SHALL hold imem_req=1 until imem_ready=1; in that cycle IRWrite=1 for exactly one cycle, then go to DECODE.
REQ-018 DECODE SHALL last one cycle and latch the opcode class: R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111 and AUIPC 0010111 (only when EN_UPPER=1).
REQ-019 Any other opcode in DECODE SHALL go to TRAP next cycle with no PCWrite and no RegWrite.
REQ-020 EXEC SHALL last one cycle; next state: BR->FETCH, LW/SW->MEM, all others->WB.
REQ-021 MEM SHALL hold dmem_req=1 and MemRead (LW) or MemWrite (SW) until dmem_ready=1; then SW->FETCH, LW->WB.
REQ-022 WB SHALL last one cycle with RegWrite=1 (never for SW/BR), then go to FETCH.
REQ-023 Decoded controls (ALUSrc, MemtoReg, ALUOp, Branch, jmp_sel, jmp, jmpr, lui, auipc) SHALL come from the latched class and stay stable from DECODE+1 through the retire cycle.
REQ-024 ALUSrc=1 for LW, SW, I, JAL, JALR, LUI, AUIPC; MemtoReg=1 for LW only; Branch=1 for BR; jmp_sel=1 for JAL/JALR.
REQ-025 RegWrite SHALL be asserted only in WB; MemRead/MemWrite only in MEM; all three SHALL be 0 in every other state.
REQ-026 Retire cycle: EXEC for BR, MEM (with dmem_ready) for SW, WB otherwise; instr_done=1 and PCWrite=1 in that cycle only.
REQ-027 For BR, PCWrite SHALL be 1 at retire regardless of branch_taken; branch_taken only drives PC-source selection.
REQ-028 instret SHALL increment by 1 on each instr_done and wrap from 2^CNT_W-1 to 0.
REQ-029 wait_cnt SHALL clear on entry to FETCH or MEM and increment each cycle the corresponding ready is 0.
REQ-030 When wait_cnt = 2^TIMEOUT_W-1 and ready is still 0, the next state SHALL be TRAP; ready=1 in that same cycle SHALL win and proceed normally.
REQ-031 TRAP SHALL drive illegal=1 and all other control outputs to 0, and SHALL hold until rst_n is asserted.

Reset
REQ-032 While rst_n=0: state=FETCH, wait_cnt=0, instret=0, latched class cleared, and all outputs 0 except state.
REQ-033 First rising edge after rst_n deasserts SHALL start FETCH with imem_req=1.
REQ-034 rst_n asserted mid-instruction, including in MEM with MemWrite=1, SHALL drop all strobes immediately, asynchronously.

Verification
REQ-035 R-type (0110011), imem_ready and dmem_ready tied 1: states 0,1,2,4; RegWrite=1 in WB only; ALUOp=10; instr_done every 4 cycles; instret=1.
REQ-036 LW with dmem_ready delayed 3 cycles: MEM lasts 4 cycles with MemRead=1; WB has MemtoReg=1 and RegWrite=1; 5+3 cycles total.
REQ-037 BR with branch_taken=0 and then with branch_taken=1: both retire in EXEC with PCWrite=1, Branch=1, ALUOp=01, RegWrite=0.
REQ-038 Opcode 1111111, and 0110111 with EN_UPPER=0: TRAP after DECODE; illegal=1 held; instret unchanged.
REQ-039 TIMEOUT_W=2, imem_ready held 0: TRAP after 4 FETCH cycles; repeat with imem_ready=1 on the 4th cycle: DECODE entered, no trap.
REQ-040 CNT_W=4, run 17 instructions: instret wraps 15->0->1; pulse rst_n low during MEM of SW: MemWrite drops without a clock edge.
